// File: rtl/uart_alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode width for the UART ALU user endpoint.
package uart_alu_pkg;

  localparam int unsigned NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SEND = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// FIFO-side bundle of the UART ALU endpoint; master is the endpoint, slave is the UART FIFO pair.
interface uart_alu_interface_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic               i_rx_empty;
  logic [NB_DATA-1:0] i_r_data;
  logic               o_rd_uart;
  logic               i_tx_full;
  logic               o_wr_uart;
  logic [NB_DATA-1:0] o_w_data;
  logic [NB_DATA-1:0] o_a;
  logic [NB_DATA-1:0] o_b;
  logic [NB_OP-1:0]   o_op;

  modport master (
    input  i_rx_empty, i_r_data, i_tx_full,
    output o_rd_uart, o_wr_uart, o_w_data, o_a, o_b, o_op
  );

  modport slave (
    output i_rx_empty, i_r_data, i_tx_full,
    input  o_rd_uart, o_wr_uart, o_w_data, o_a, o_b, o_op
  );
endinterface

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: result = a op b truncated to NB_DATA, unknown opcodes give 0.
module alu
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = uart_alu_pkg::NB_OP
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  // Shifts use the full b; oversized amounts saturate to sign fill / zero.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRA:  o_result = NB_DATA'($signed(i_a) >>> i_b);
      OP_SRL:  o_result = i_a >> i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// UART user endpoint: pops A, B, OP frames from rx FIFO, pushes alu(A,B,OP) to tx FIFO.
// Optional partial-frame timeout enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned NB_OP         = uart_alu_pkg::NB_OP,
  parameter int unsigned TIMEOUT_TICKS = 1000000,
  parameter int unsigned NB_TIMEOUT    = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_alu_interface_if.master bus
);

  if ((64'(1) << NB_TIMEOUT) <= 64'(TIMEOUT_TICKS)) begin : g_bad_timeout_width
    $error("NB_TIMEOUT too narrow for TIMEOUT_TICKS");
  end

  state_t             state, state_next;
  logic               pop;
  logic               tmo_hit;
  logic [NB_DATA-1:0] result_q, result_d, alu_res;
  logic               rd_d, wr_d;
  logic [NB_DATA-1:0] a_d, b_d, w_data_d;
  logic [NB_OP-1:0]   op_d;

  // The FIFO head still shows the popped word while o_rd_uart is high, so never re-pop then.
  always_comb begin
    pop = !bus.i_rx_empty && !bus.o_rd_uart;
  end

`ifdef UART_IF_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] tmo_cnt;

  always_comb begin
    tmo_hit = ((state == S_B) || (state == S_OP)) && bus.i_rx_empty &&
              (tmo_cnt == NB_TIMEOUT'(TIMEOUT_TICKS - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if (pop || !((state == S_B) || (state == S_OP))) begin
      tmo_cnt <= '0;
    end else if (bus.i_rx_empty) begin
      tmo_cnt <= tmo_cnt + NB_TIMEOUT'(1);
    end
  end
`else
  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .i_a      (bus.o_a),
    .i_b      (bus.o_b),
    .i_op     (bus.o_op),
    .o_result (alu_res)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_A;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:    if (pop) state_next = S_B;
      S_B:    if (pop) state_next = S_OP;   else if (tmo_hit) state_next = S_A;
      S_OP:   if (pop) state_next = S_CALC; else if (tmo_hit) state_next = S_A;
      S_CALC: state_next = S_SEND;
      S_SEND: if (!bus.i_tx_full) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  // Next values of the registered outputs; operands hold across timeouts.
  always_comb begin
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    a_d      = bus.o_a;
    b_d      = bus.o_b;
    op_d     = bus.o_op;
    w_data_d = bus.o_w_data;
    result_d = result_q;
    case (state)
      S_A: if (pop) begin
        rd_d = 1'b1;
        a_d  = bus.i_r_data;
      end
      S_B: if (pop) begin
        rd_d = 1'b1;
        b_d  = bus.i_r_data;
      end
      S_OP: if (pop) begin
        rd_d = 1'b1;
        op_d = bus.i_r_data[NB_OP-1:0];
      end
      S_CALC: result_d = alu_res;
      S_SEND: if (!bus.i_tx_full) begin
        wr_d     = 1'b1;
        w_data_d = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_rd_uart <= 1'b0;
      bus.o_wr_uart <= 1'b0;
      bus.o_w_data  <= '0;
      bus.o_a       <= '0;
      bus.o_b       <= '0;
      bus.o_op      <= '0;
      result_q      <= '0;
    end else begin
      bus.o_rd_uart <= rd_d;
      bus.o_wr_uart <= wr_d;
      bus.o_w_data  <= w_data_d;
      bus.o_a       <= a_d;
      bus.o_b       <= b_d;
      bus.o_op      <= op_d;
      result_q      <= result_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: rx FIFO model feeds frames, tx pushes checked in order.
module tb_uart_alu_interface;

  logic clk;
  logic i_reset;

  uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_interface #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_TICKS(16), .NB_TIMEOUT(20)
  ) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int vectors = 0;
  int errors  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [15:0] ext;
    int sh;
    sh = (b > 8'd8) ? 8 : int'(b);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: begin ext = {{8{a[7]}}, a}; ext = ext >> sh; return ext[7:0]; end
      6'h02: return (b >= 8'd8) ? 8'h00 : (a >> b);
      default: return 8'h00;
    endcase
  endfunction

  // FIFO model plus tx monitor, all on the falling edge.
  always @(negedge clk) begin
    if (bus.o_rd_uart || bus.o_wr_uart)
      check("rd_wr_exclusive", 32'(bus.o_rd_uart & bus.o_wr_uart), 32'd0);
    if (bus.o_rd_uart) begin
      rd_cnt++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (bus.o_wr_uart) begin
      wr_cnt++;
      check("sb_has_entry", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) check("w_data", 32'(bus.o_w_data), 32'(expq.pop_front()));
    end
    bus.i_rx_empty = (rxq.size() == 0);
    bus.i_r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    expq.push_back(model(a, b, op[5:0]));
  endtask

  task automatic wait_wr(input int target);
    int k = 0;
    while (wr_cnt < target && k < 300) begin @(posedge clk); k++; end
    check("wr_wait", 32'(wr_cnt >= target), 32'd1);
  endtask

  task automatic wait_rd(input int target);
    int k = 0;
    while (rd_cnt < target && k < 300) begin @(posedge clk); k++; end
    check("rd_wait", 32'(rd_cnt >= target), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  int rd_base, wr_base;

  initial begin
    i_reset       = 1'b1;
    bus.i_tx_full = 1'b0;
    cycles(3);
    @(negedge clk);
    check("rst_rd",     32'(bus.o_rd_uart), 32'd0);
    check("rst_wr",     32'(bus.o_wr_uart), 32'd0);
    check("rst_w_data", 32'(bus.o_w_data),  32'd0);
    check("rst_a",      32'(bus.o_a),       32'd0);
    check("rst_b",      32'(bus.o_b),       32'd0);
    check("rst_op",     32'(bus.o_op),      32'd0);
    i_reset = 1'b0;

    // Basic ADD frame.
    @(posedge clk);
    wr_base = wr_cnt;
    send_frame(8'h05, 8'h03, 8'h20);
    wait_wr(wr_base + 1);
    cycles(5);
    @(negedge clk);
    check("t1_a",  32'(bus.o_a),  32'h05);
    check("t1_b",  32'(bus.o_b),  32'h03);
    check("t1_op", 32'(bus.o_op), 32'h20);
    check("t1_wr_pulses", 32'(wr_cnt - wr_base), 32'd1);

    // Streamed arithmetic/logic frames, including an undefined opcode.
    @(posedge clk);
    wr_base = wr_cnt;
    send_frame(8'h03, 8'h05, 8'h22);
    send_frame(8'hFF, 8'h02, 8'h20);
    send_frame(8'h12, 8'h34, 8'h3F);
    send_frame(8'hC3, 8'h5A, 8'h26);
    send_frame(8'h0F, 8'h30, 8'h25);
    wait_wr(wr_base + 5);

    // Shifts, including an oversized shift amount; upper OP bits ignored.
    @(posedge clk);
    wr_base = wr_cnt;
    send_frame(8'h80, 8'h02, 8'h03);
    send_frame(8'h80, 8'h02, 8'h02);
    send_frame(8'h80, 8'h09, 8'h03);
    send_frame(8'h80, 8'h09, 8'hC2);
    wait_wr(wr_base + 4);
    cycles(3);
    @(negedge clk);
    check("t3_op_masked", 32'(bus.o_op), 32'h02);

    // Back-pressure in S_SEND with more bytes waiting in rx.
    @(posedge clk);
    bus.i_tx_full = 1'b1;
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    send_frame(8'h01, 8'h02, 8'h20);
    send_frame(8'hF0, 8'h0E, 8'h27);
    wait_rd(rd_base + 3);
    cycles(2);
    rd_base = rd_cnt;
    cycles(10);
    check("t4_no_rd_full", 32'(rd_cnt - rd_base), 32'd0);
    check("t4_no_wr_full", 32'(wr_cnt - wr_base), 32'd0);
    @(negedge clk);
    bus.i_tx_full = 1'b0;
    wait_wr(wr_base + 2);
    cycles(4);
    check("t4_wr_pulses", 32'(wr_cnt - wr_base), 32'd2);

    // Reset mid-frame drops the partial frame.
    @(posedge clk);
    rd_base = rd_cnt;
    rxq.push_back(8'h07);
    wait_rd(rd_base + 1);
    @(negedge clk);
    i_reset = 1'b1;
    cycles(2);
    @(negedge clk);
    i_reset = 1'b0;
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    send_frame(8'h01, 8'h01, 8'h20);
    wait_wr(wr_base + 1);
    cycles(8);
    check("t5_rd_pulses", 32'(rd_cnt - rd_base), 32'd3);
    check("t5_wr_pulses", 32'(wr_cnt - wr_base), 32'd1);

`ifdef UART_IF_TIMEOUT_EN
    // Partial frame abandoned after idle, operands keep last values.
    @(posedge clk);
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    rxq.push_back(8'h09);
    wait_rd(rd_base + 1);
    cycles(24);
    @(negedge clk);
    check("t6_a_kept",  32'(bus.o_a), 32'h09);
    check("t6_b_kept",  32'(bus.o_b), 32'h01);
    check("t6_no_wr",   32'(wr_cnt - wr_base), 32'd0);
    @(posedge clk);
    send_frame(8'h02, 8'h03, 8'h20);
    wait_wr(wr_base + 1);
    cycles(4);
    check("t6_rd_pulses", 32'(rd_cnt - rd_base), 32'd4);
`endif

    check("sb_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
